// File: rtl/mult_sequencer.sv
// Iterative shift-add unsigned multiplier: accepts an operand pair, runs WIDTH
// partial-product steps (one per clock), then holds the 2*WIDTH-bit product until taken.
module mult_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     a_q;
   logic [2*WIDTH-1:0]   p_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 accept;

   // One multiply step: conditionally add A to the upper half, then shift the
   // WIDTH+1-bit sum (its carry included) back in from the top.
   function automatic logic [2*WIDTH-1:0] shift_add_step(
      input logic [2*WIDTH-1:0] p,
      input logic [WIDTH-1:0]   a
   );
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
      return {sum, p[WIDTH-1:1]};
   endfunction

   assign accept = in_valid & in_ready;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (cnt_q == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            // out_ready feeds in_ready directly so a consume and a new accept share one edge
            in_ready = out_ready;
            if (out_ready) state_nxt = in_valid ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q   <= '0;
         p_q   <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q   <= in_a;
            p_q   <= {{WIDTH{1'b0}}, in_b};
            cnt_q <= '0;
         end else if (state == RUN) begin
            p_q   <= shift_add_step(p_q, a_q);
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_valid   = (state == DONE);
   assign busy        = (state == RUN);
   assign out_product = p_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomised and directed bench for mult_sequencer (WIDTH=8) against a
// plain-arithmetic product model with latency/handshake expectations.
module tb_mult_sequencer;

   localparam int W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_a;
   logic [W-1:0]      in_b;
   logic              out_valid;
   logic              out_ready;
   logic [2*W-1:0]    out_product;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   mult_sequencer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_product(out_product),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction: accept a*b, expect W-cycle latency and W busy cycles,
   // hold backpressure for `hold` cycles with a stray in_valid, then consume.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [2*W-1:0] exp_p;
      int lat, bcnt;
      bit got;
      exp_p = 16'(a) * 16'(b);
      out_ready = 1'b0;
      chk("idle_in_ready", in_ready, 1);
      in_a = a; in_b = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom);
      lat = 0; bcnt = 0; got = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) begin got = 1; break; end
         bcnt += int'(busy);
         tick();
         lat++;
      end
      chk("timeout", 32'(got), 1);
      chk("latency", lat, W);
      chk("busy_cycles", bcnt, W);
      chk("product", out_product, exp_p);
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == 1);
         in_a = W'($urandom); in_b = W'($urandom);
         #1 chk("bp_in_ready", in_ready, 0);
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_product", out_product, exp_p);
         chk("bp_busy", busy, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1 chk("done_in_ready", in_ready, 1);
      tick();
      chk("consumed_valid", out_valid, 0);
      chk("consumed_busy", busy, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [2*W-1:0] res_q[$];
      int             cyc_q[$];
      int             k;

      rst_n = 1'b0; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_product", out_product, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", busy, 0);

      do_op(8'd13, 8'd11, 5);
      do_op(8'd255, 8'd255, 0);
      do_op(8'd255, 8'd1, 1);
      do_op(8'd0, 8'd200, 0);
      do_op(8'd200, 8'd0, 2);

      // back-to-back with out_ready held high; in_valid held while busy must be ignored
      out_ready = 1'b1;
      in_a = 8'd3; in_b = 8'd5; in_valid = 1'b1;
      tick();
      in_a = 8'd7; in_b = 8'd9;
      k = 0;
      while (k < 40 && res_q.size() < 2) begin
         if (busy && res_q.size() == 1) in_valid = 1'b0;
         tick();
         k++;
         if (out_valid) begin
            res_q.push_back(out_product);
            cyc_q.push_back(k);
         end
      end
      in_valid = 1'b0;
      chk("b2b_count", res_q.size(), 2);
      if (res_q.size() == 2) begin
         chk("b2b_first", res_q[0], 16'h000F);
         chk("b2b_second", res_q[1], 16'h003F);
         chk("b2b_first_lat", cyc_q[0], W);
         chk("b2b_spacing", cyc_q[1] - cyc_q[0], W + 1);
      end
      tick();
      chk("b2b_drained", out_valid, 0);
      out_ready = 1'b0;

      // reset mid-RUN with a simultaneous in_valid: reset wins
      in_a = 8'd100; in_b = 8'd100; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0; in_valid = 1'b1;
      tick();
      chk("midrun_rst_valid", out_valid, 0);
      chk("midrun_rst_busy", busy, 0);
      chk("midrun_rst_in_ready", in_ready, 1);
      chk("midrun_rst_product", out_product, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      do_op(8'd2, 8'd3, 0);

      // reset while holding a result
      in_a = 8'd17; in_b = 8'd19; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (W) tick();
      chk("pre_rst_done", out_valid, 1);
      rst_n = 1'b0; out_ready = 1'b1;
      tick();
      chk("done_rst_valid", out_valid, 0);
      rst_n = 1'b1; out_ready = 1'b0;
      tick();

      for (int i = 0; i < 12; i++)
         do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
